// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline definitions: stall-controller state encodings, counter
// width default and the register-address width used by the hazard unit.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    STATE_RUN       = 2'd0,
    STATE_LU_BUBBLE = 2'd1,
    STATE_MEM_HOLD  = 2'd2
  } state_t;

  localparam int CNT_W_DEFAULT = 16;
  localparam int REG_ADDR_W    = 3;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and pipeline-register controls of the stall controller.
// The slave side is the controller; the master side is its environment.
interface pipeline_stall_ctrl_if
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);
  logic             i_load_use;
  logic             i_mem_busy;
  logic             i_branch_taken;
  logic             o_pc_write;
  logic             o_ifid_write;
  logic             o_ifid_flush;
  logic             o_idex_write;
  logic             o_idex_bubble;
  logic             o_exmem_write;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;
  logic             o_mem_timeout;

  modport slave (
    input  i_load_use, i_mem_busy, i_branch_taken,
    output o_pc_write, o_ifid_write, o_ifid_flush, o_idex_write,
           o_idex_bubble, o_exmem_write, o_state, o_stall_cnt,
           o_flush_cnt, o_mem_timeout
  );

  modport master (
    output i_load_use, i_mem_busy, i_branch_taken,
    input  o_pc_write, o_ifid_write, o_ifid_flush, o_idex_write,
           o_idex_bubble, o_exmem_write, o_state, o_stall_cnt,
           o_flush_cnt, o_mem_timeout
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Up-counter that stops at MAX instead of wrapping; clr has priority.
module sat_counter #(
  parameter int           W   = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count register: clear, else increment until MAX is reached
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: turns load-use, mem-busy and
// branch-taken hazards into per-stage write/flush/bubble enables with
// zero latency, bounds load-use stalls to one bubble per load and keeps
// saturating stall/flush counters plus a sticky mem-busy timeout.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int MEM_HOLD_MAX = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  pipeline_stall_ctrl_if.slave bus
);

  localparam logic [7:0] HOLD_MAX  = 8'(MEM_HOLD_MAX);
  localparam logic [7:0] HOLD_LAST = 8'(MEM_HOLD_MAX - 1);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_bubble;
  logic       exmem_write;
  logic       stall_inc;
  logic       flush_inc;
  logic       hold_inc;
  logic       hold_clr;
  logic [7:0] hold_cnt;
  logic       timeout_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= STATE_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Prioritised hazard decode: stage enables and next state
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    exmem_write = 1'b1;
    state_d     = STATE_RUN;
    if (i_rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (bus.i_mem_busy) begin
      // Whole pipe frozen; a branch in EX re-presents after release
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_d     = STATE_MEM_HOLD;
    end else if (bus.i_branch_taken) begin
      // Wrong-path instructions squashed; a concurrent load-use dies with them
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (bus.i_load_use && (state_q != STATE_LU_BUBBLE)) begin
      // One bubble per load; afterwards the load sits in MEM and forwards
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = STATE_LU_BUBBLE;
    end
    if (state_q == 2'd3) begin
      state_d = STATE_RUN;
    end
  end

  assign stall_inc = !i_rst && !pc_write;
  assign flush_inc = !i_rst && ifid_flush;
  assign hold_inc  = !i_rst && bus.i_mem_busy;
  assign hold_clr  = i_rst || !bus.i_mem_busy;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (i_clk),
    .clr (i_rst),
    .inc (stall_inc),
    .cnt (bus.o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (i_clk),
    .clr (i_rst),
    .inc (flush_inc),
    .cnt (bus.o_flush_cnt)
  );

  sat_counter #(.W(8), .MAX(HOLD_MAX)) u_hold_cnt (
    .clk (i_clk),
    .clr (hold_clr),
    .inc (hold_inc),
    .cnt (hold_cnt)
  );

  // Sticky timeout: set on the edge where the busy run reaches the limit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timeout_q <= 1'b0;
    end else if (hold_inc && (hold_cnt >= HOLD_LAST)) begin
      timeout_q <= 1'b1;
    end
  end

  assign bus.o_pc_write    = pc_write;
  assign bus.o_ifid_write  = ifid_write;
  assign bus.o_ifid_flush  = ifid_flush;
  assign bus.o_idex_write  = idex_write;
  assign bus.o_idex_bubble = idex_bubble;
  assign bus.o_exmem_write = exmem_write;
  assign bus.o_state       = state_q;
  assign bus.o_mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with a narrow counter width and
// a short mem-hold limit so saturation and timeout are reachable quickly.
module tb_pipeline_stall_ctrl;
  import pipeline_stall_ctrl_pkg::*;

  localparam int CW = 4;
  localparam int HM = 3;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}
  localparam logic [5:0] CTL_RST    = 6'b001111;
  localparam logic [5:0] CTL_RUN    = 6'b110101;
  localparam logic [5:0] CTL_STALL  = 6'b000111;
  localparam logic [5:0] CTL_BRANCH = 6'b111111;
  localparam logic [5:0] CTL_FREEZE = 6'b000000;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_stall_ctrl #(.CNT_W(CW), .MEM_HOLD_MAX(HM)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [5:0] ctl;
  assign ctl = {bus.o_pc_write, bus.o_ifid_write, bus.o_ifid_flush,
                bus.o_idex_write, bus.o_idex_bubble, bus.o_exmem_write};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(input logic lu, input logic mb, input logic bt);
    bus.i_load_use     = lu;
    bus.i_mem_busy     = mb;
    bus.i_branch_taken = bt;
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    set_in(0, 0, 0);
    tick();
    i_rst = 1'b0;
    #1;
  endtask

  initial begin
    set_in(0, 0, 0);

    // Reset held two cycles
    tick();
    check_val("rst_ctl_c1", 32'(ctl), 32'(CTL_RST));
    tick();
    check_val("rst_ctl_c2", 32'(ctl), 32'(CTL_RST));
    i_rst = 1'b0;
    #1;
    check_val("rst_state", 32'(bus.o_state), 0);
    check_val("rst_stall", 32'(bus.o_stall_cnt), 0);
    check_val("rst_flush", 32'(bus.o_flush_cnt), 0);
    check_val("rst_tmo", 32'(bus.o_mem_timeout), 0);
    check_val("run_ctl", 32'(ctl), 32'(CTL_RUN));

    // Single load-use pulse
    set_in(1, 0, 0);
    check_val("lu1_ctl", 32'(ctl), 32'(CTL_STALL));
    tick();
    set_in(0, 0, 0);
    check_val("lu1_state", 32'(bus.o_state), 1);
    check_val("lu1_stall", 32'(bus.o_stall_cnt), 1);
    check_val("lu1_ctl_after", 32'(ctl), 32'(CTL_RUN));
    tick();
    check_val("lu1_state_run", 32'(bus.o_state), 0);

    // Load-use held three cycles: stall, ignored, stall
    do_reset();
    set_in(1, 0, 0);
    check_val("lu3_c1", 32'(ctl), 32'(CTL_STALL));
    tick();
    check_val("lu3_c2", 32'(ctl), 32'(CTL_RUN));
    tick();
    check_val("lu3_c3_state", 32'(bus.o_state), 0);
    check_val("lu3_c3", 32'(ctl), 32'(CTL_STALL));
    tick();
    set_in(0, 0, 0);
    check_val("lu3_stall", 32'(bus.o_stall_cnt), 2);
    check_val("lu3_state", 32'(bus.o_state), 1);

    // Branch and load-use together: branch wins
    do_reset();
    set_in(1, 0, 1);
    check_val("br_lu_ctl", 32'(ctl), 32'(CTL_BRANCH));
    tick();
    set_in(0, 0, 0);
    check_val("br_lu_flush", 32'(bus.o_flush_cnt), 1);
    check_val("br_lu_stall", 32'(bus.o_stall_cnt), 0);
    check_val("br_lu_state", 32'(bus.o_state), 0);

    // Mem busy four cycles with a branch waiting in EX
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 1);
      check_val($sformatf("mb_ctl_%0d", i), 32'(ctl), 32'(CTL_FREEZE));
      tick();
      check_val($sformatf("mb_state_%0d", i), 32'(bus.o_state), 2);
      check_val($sformatf("mb_tmo_%0d", i), 32'(bus.o_mem_timeout), (i >= 2) ? 1 : 0);
    end
    check_val("mb_stall", 32'(bus.o_stall_cnt), 4);
    check_val("mb_flush0", 32'(bus.o_flush_cnt), 0);
    set_in(0, 0, 1);
    check_val("mb_release_ctl", 32'(ctl), 32'(CTL_BRANCH));
    tick();
    set_in(0, 0, 0);
    check_val("mb_release_flush", 32'(bus.o_flush_cnt), 1);
    check_val("mb_release_stall", 32'(bus.o_stall_cnt), 4);
    check_val("mb_release_state", 32'(bus.o_state), 0);
    check_val("tmo_sticky", 32'(bus.o_mem_timeout), 1);
    tick();
    check_val("tmo_sticky2", 32'(bus.o_mem_timeout), 1);
    do_reset();
    check_val("tmo_cleared", 32'(bus.o_mem_timeout), 0);

    // Busy runs of two broken by an idle cycle never reach the limit
    for (int i = 0; i < 5; i++) begin
      set_in(0, (i != 2), 0);
      tick();
    end
    set_in(0, 0, 0);
    check_val("tmo_broken_run", 32'(bus.o_mem_timeout), 0);

    // Load-use released from MEM_HOLD is re-evaluated that cycle
    do_reset();
    set_in(1, 1, 0);
    tick();
    set_in(1, 0, 0);
    check_val("hold_lu_ctl", 32'(ctl), 32'(CTL_STALL));
    tick();
    set_in(0, 0, 0);
    check_val("hold_lu_state", 32'(bus.o_state), 1);

    // Stall counter saturates at all ones
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 1, 0);
      tick();
    end
    set_in(0, 0, 0);
    check_val("stall_sat", 32'(bus.o_stall_cnt), 15);

    // Reset mid-stall
    do_reset();
    set_in(0, 1, 0);
    tick();
    i_rst = 1'b1;
    #1;
    check_val("midrst_ctl", 32'(ctl), 32'(CTL_RST));
    tick();
    i_rst = 1'b0;
    set_in(0, 0, 0);
    check_val("midrst_state", 32'(bus.o_state), 0);
    check_val("midrst_stall", 32'(bus.o_stall_cnt), 0);
    check_val("midrst_ctl_run", 32'(ctl), 32'(CTL_RUN));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
